// File: rtl/protect_stim_pkg.sv
// ============================================================================
//  Module      : protect_stim_pkg
//  Description : Shared state encoding, mode constants and the expected-result
//                function for the protected-DUT stimulus sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package protect_stim_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RST_HOLD = 3'd1,
        S_DRIVE    = 3'd2,
        S_WAIT_RSP = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam int MODE_ADD = 0;
    localparam int MODE_SUB = 1;
    localparam int MODE_XOR = 2;

    localparam int K_WIDTH = 16;

    // Operates at the widest supported width; callers truncate to their WIDTH,
    // which gives modulo-2^WIDTH results for all three modes.
    function automatic logic [63:0] expected_fn(input int mode,
                                                input logic [63:0] a,
                                                input logic [63:0] b);
        case (mode)
            MODE_SUB: return a - b;
            MODE_XOR: return a ^ b;
            default:  return a + b;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/protect_stim_vecgen.sv
// ============================================================================
//  Module      : protect_stim_vecgen
//  Description : Vector index counter and a/b operand stepping registers with
//                a registered last-vector flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module protect_stim_vecgen
    import protect_stim_pkg::*;
#(
    parameter int          WIDTH  = 32,
    parameter int          NVEC   = 4,
    parameter logic [63:0] A0     = 64'd5,
    parameter logic [63:0] A_STEP = 64'd1,
    parameter logic [63:0] B0     = 64'd7,
    parameter logic [63:0] B_STEP = 64'd0
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             load,
    input  logic             advance,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             last
);

    localparam logic [K_WIDTH-1:0] c_LAST_K = K_WIDTH'(NVEC - 1);

    logic [K_WIDTH-1:0] r_k;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_k  <= '0;
            a    <= '0;
            b    <= '0;
            last <= 1'b0;
        end else if (load) begin
            r_k  <= '0;
            a    <= WIDTH'(A0);
            b    <= WIDTH'(B0);
            last <= (c_LAST_K == '0);
        end else if (advance) begin
            r_k  <= r_k + K_WIDTH'(1);
            a    <= a + WIDTH'(A_STEP);
            b    <= b + WIDTH'(B_STEP);
            last <= ((r_k + K_WIDTH'(1)) == c_LAST_K);
        end
    end

endmodule

`default_nettype wire

// File: rtl/protect_stim_seq.sv
// ============================================================================
//  Module      : protect_stim_seq
//  Description : Drives stepped operand pairs into a DUT over valid/ready and
//                checks each response against an internally computed result.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module protect_stim_seq
    import protect_stim_pkg::*;
#(
    parameter int          WIDTH      = 32,
    parameter int          NVEC       = 4,
    parameter int          MODE       = 0,
    parameter logic [63:0] A0         = 64'd5,
    parameter logic [63:0] A_STEP     = 64'd1,
    parameter logic [63:0] B0         = 64'd7,
    parameter logic [63:0] B_STEP     = 64'd0,
    parameter int          RST_CYCLES = 2,
    parameter int          TIMEOUT    = 16
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             start,
    output logic             dut_reset_l,
    output logic             dut_valid,
    input  logic             dut_ready,
    output logic [WIDTH-1:0] dut_a,
    output logic [WIDTH-1:0] dut_b,
    input  logic             rsp_valid,
    input  logic [WIDTH-1:0] rsp_x,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic             timeout
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [TW-1:0] c_TIMEOUT  = TW'(TIMEOUT);
    localparam logic [RW-1:0] c_RST_LOAD = RW'(RST_CYCLES - 1);

    state_t           r_state;
    logic [TW-1:0]    r_timer;
    logic [RW-1:0]    r_rst_cnt;
    logic [WIDTH-1:0] r_expected;

    logic             w_load;
    logic             w_advance;
    logic             w_last;
    logic             w_mismatch;
    logic [WIDTH-1:0] w_exp;
    logic [15:0]      w_err_inc;

    assign w_load     = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_advance  = (r_state == S_WAIT_RSP) && rsp_valid && !w_last;
    assign w_exp      = WIDTH'(expected_fn(MODE, 64'(dut_a), 64'(dut_b)));
    assign w_mismatch = (rsp_x != r_expected);
    assign w_err_inc  = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;

    protect_stim_vecgen #(
        .WIDTH  (WIDTH),
        .NVEC   (NVEC),
        .A0     (A0),
        .A_STEP (A_STEP),
        .B0     (B0),
        .B_STEP (B_STEP)
    ) u_vecgen (
        .clk     (clk),
        .reset_l (reset_l),
        .load    (w_load),
        .advance (w_advance),
        .a       (dut_a),
        .b       (dut_b),
        .last    (w_last)
    );

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_rst_cnt   <= '0;
            r_expected  <= '0;
            dut_reset_l <= 1'b0;
            dut_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_count   <= '0;
            timeout     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_RST_HOLD;
                        r_rst_cnt   <= c_RST_LOAD;
                        dut_reset_l <= 1'b0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        err_count   <= '0;
                        timeout     <= 1'b0;
                    end else if ((r_state == S_DONE) && rsp_valid) begin
                        err_count <= w_err_inc;
                        pass      <= 1'b0;
                    end
                end
                S_RST_HOLD: begin
                    if (r_rst_cnt == '0) begin
                        r_state     <= S_DRIVE;
                        dut_reset_l <= 1'b1;
                        dut_valid   <= 1'b1;
                    end else begin
                        r_rst_cnt <= r_rst_cnt - RW'(1);
                    end
                end
                S_DRIVE: begin
                    if (rsp_valid) begin
                        err_count <= w_err_inc;
                    end
                    if (dut_ready) begin
                        r_state    <= S_WAIT_RSP;
                        dut_valid  <= 1'b0;
                        r_expected <= w_exp;
                        r_timer    <= TW'(1);
                    end
                end
                S_WAIT_RSP: begin
                    // A response arriving on the expiry cycle is still checked normally.
                    if (rsp_valid) begin
                        if (w_mismatch) begin
                            err_count <= w_err_inc;
                        end
                        if (w_last) begin
                            r_state <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= !w_mismatch && (err_count == '0) && !timeout;
                        end else begin
                            r_state   <= S_DRIVE;
                            dut_valid <= 1'b1;
                        end
                    end else if (r_timer == c_TIMEOUT) begin
                        r_state   <= S_DONE;
                        timeout   <= 1'b1;
                        err_count <= w_err_inc;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= 1'b0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_protect_stim_seq.sv
// ============================================================================
//  Module      : tb_protect_stim_seq
//  Description : Self-checking bench: an add/32-bit and a subtract/8-bit
//                sequencer driven by a scripted DUT responder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_protect_stim_seq;

    logic        clk = 1'b0;
    logic        reset_l, start, dut_ready, rsp_valid, sel;
    logic [31:0] rsp_x;

    logic        rl1, v1, busy1, done1, pass1, to1;
    logic [31:0] a1, b1;
    logic [15:0] err1;
    logic        rl2, v2, busy2, done2, pass2, to2;
    logic [7:0]  a2, b2;
    logic [15:0] err2;

    logic        m_rl, m_v, m_busy, m_done, m_pass, m_to;
    logic [31:0] m_a, m_b;
    logic [15:0] m_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    protect_stim_seq #(
        .WIDTH(32), .NVEC(3), .MODE(0), .A0(64'd5), .A_STEP(64'd1),
        .B0(64'd7), .B_STEP(-5), .RST_CYCLES(2), .TIMEOUT(16)
    ) u_add (
        .clk(clk), .reset_l(reset_l), .start(start & ~sel),
        .dut_reset_l(rl1), .dut_valid(v1), .dut_ready(dut_ready & ~sel),
        .dut_a(a1), .dut_b(b1), .rsp_valid(rsp_valid & ~sel), .rsp_x(rsp_x),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .timeout(to1)
    );

    protect_stim_seq #(
        .WIDTH(8), .NVEC(5), .MODE(1), .A0(64'd3), .A_STEP(64'd37),
        .B0(64'd5), .B_STEP(64'd200), .RST_CYCLES(2), .TIMEOUT(16)
    ) u_sub (
        .clk(clk), .reset_l(reset_l), .start(start & sel),
        .dut_reset_l(rl2), .dut_valid(v2), .dut_ready(dut_ready & sel),
        .dut_a(a2), .dut_b(b2), .rsp_valid(rsp_valid & sel), .rsp_x(rsp_x[7:0]),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .timeout(to2)
    );

    assign m_rl   = sel ? rl2   : rl1;
    assign m_v    = sel ? v2    : v1;
    assign m_busy = sel ? busy2 : busy1;
    assign m_done = sel ? done2 : done1;
    assign m_pass = sel ? pass2 : pass1;
    assign m_to   = sel ? to2   : to1;
    assign m_a    = sel ? {24'd0, a2} : a1;
    assign m_b    = sel ? {24'd0, b2} : b1;
    assign m_err  = sel ? err2  : err1;

    // Reference: vector k operands are first value + k*step, modulo 2^WIDTH.
    function automatic logic [31:0] mdl_a(input int k);
        return sel ? 32'((3 + 37 * k) & 255) : 32'(5 + k);
    endfunction

    function automatic logic [31:0] mdl_b(input int k);
        return sel ? 32'((5 + 200 * k) & 255) : 32'(7 - 5 * k);
    endfunction

    function automatic logic [31:0] mdl_exp(input int k);
        logic [31:0] a, b;
        a = mdl_a(k);
        b = mdl_b(k);
        return sel ? ((a - b) & 32'hFF) : (a + b);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string t);
        chk({t, "_dut_reset_l"}, m_rl, 0);
        chk({t, "_dut_valid"}, m_v, 0);
        chk({t, "_dut_a"}, m_a, 0);
        chk({t, "_dut_b"}, m_b, 0);
        chk({t, "_busy"}, m_busy, 0);
        chk({t, "_done"}, m_done, 0);
        chk({t, "_pass"}, m_pass, 0);
        chk({t, "_err"}, m_err, 0);
        chk({t, "_timeout"}, m_to, 0);
    endtask

    task automatic chk_end(input string t, input bit ep, input int ee, input bit et);
        chk({t, "_done"}, m_done, 1);
        chk({t, "_busy"}, m_busy, 0);
        chk({t, "_pass"}, m_pass, ep);
        chk({t, "_err"}, m_err, ee);
        chk({t, "_timeout"}, m_to, et);
    endtask

    task automatic start_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", m_busy, 1);
        chk("start_dutrst_low", m_rl, 0);
        @(negedge clk);
        chk("hold_dutrst_low", m_rl, 0);
        chk("hold_no_valid", m_v, 0);
        @(negedge clk);
        chk("release_dutrst", m_rl, 1);
    endtask

    task automatic do_vec(input int k, input int rdly, input int lat,
                          input bit corrupt, input bit silent);
        int          n;
        bit          stable;
        logic [31:0] ea, eb;
        ea = mdl_a(k);
        eb = mdl_b(k);
        n  = 0;
        while (!m_v && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("valid_wait", m_v, 1);
        chk("op_a", m_a, ea);
        chk("op_b", m_b, eb);
        stable = 1'b1;
        repeat (rdly) begin
            dut_ready = 1'b0;
            @(negedge clk);
            if (!(m_v && m_a == ea && m_b == eb)) stable = 1'b0;
        end
        chk("hold_stable", stable, 1);
        dut_ready = 1'b1;
        @(negedge clk);
        dut_ready = 1'b0;
        chk("valid_drop", m_v, 0);
        if (!silent) begin
            repeat (lat - 1) @(negedge clk);
            rsp_valid = 1'b1;
            rsp_x     = mdl_exp(k) + (corrupt ? 32'd1 : 32'd0);
            @(negedge clk);
            rsp_valid = 1'b0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        sel = 1'b0; reset_l = 1'b0; start = 1'b0;
        dut_ready = 1'b0; rsp_valid = 1'b0; rsp_x = '0;
        repeat (2) @(negedge clk);
        chk_reset_vals("por");
        reset_l = 1'b1;
        @(negedge clk);

        // Clean add run with random handshake/response timing
        start_run();
        for (int k = 0; k < 3; k++) do_vec(k, $urandom_range(0, 3), $urandom_range(1, 16), 0, 0);
        chk_end("add_clean", 1, 0, 0);

        // Backpressure
        start_run();
        for (int k = 0; k < 3; k++) do_vec(k, 5, $urandom_range(1, 16), 0, 0);
        chk_end("backpressure", 1, 0, 0);

        // Corrupt first response; the run still completes
        start_run();
        for (int k = 0; k < 3; k++) do_vec(k, $urandom_range(0, 2), $urandom_range(1, 6), k == 0, 0);
        chk_end("corrupt", 0, 1, 0);

        // Silent DUT after the second handshake
        start_run();
        do_vec(0, 0, $urandom_range(1, 8), 0, 0);
        do_vec(1, 0, 1, 0, 1);
        n = 0;
        while (!m_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_latency", n, 16);
        chk_end("timeout", 0, 1, 1);
        chk("timeout_no_valid", m_v, 0);

        // Response on the expiry cycle wins
        start_run();
        for (int k = 0; k < 3; k++) do_vec(k, 0, 16, 0, 0);
        chk_end("edge_rsp", 1, 0, 0);

        // Spurious response in DRIVE and in DONE
        start_run();
        rsp_valid = 1'b1;
        rsp_x     = $urandom;
        @(negedge clk);
        rsp_valid = 1'b0;
        chk("spur_drive_err", m_err, 1);
        for (int k = 0; k < 3; k++) do_vec(k, 0, $urandom_range(1, 4), 0, 0);
        chk_end("spur", 0, 1, 0);
        rsp_valid = 1'b1;
        @(negedge clk);
        rsp_valid = 1'b0;
        chk("spur_done_err", m_err, 2);

        // Reset mid-run during WAIT_RSP
        start_run();
        do_vec(0, 0, 1, 0, 1);
        repeat (3) @(negedge clk);
        reset_l = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        reset_l = 1'b1;
        @(negedge clk);
        start_run();
        for (int k = 0; k < 3; k++) do_vec(k, $urandom_range(0, 3), $urandom_range(1, 16), 0, 0);
        chk_end("after_rst", 1, 0, 0);

        // 8-bit subtract instance
        sel = 1'b1;
        @(negedge clk);
        start_run();
        for (int k = 0; k < 5; k++) do_vec(k, $urandom_range(0, 3), $urandom_range(1, 16), 0, 0);
        chk_end("sub_clean", 1, 0, 0);
        start_run();
        for (int k = 0; k < 5; k++) do_vec(k, $urandom_range(0, 2), $urandom_range(1, 5), k == 2, 0);
        chk_end("sub_corrupt", 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
